// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand/result handshake bundle for pipelined_addsub.
//
// Signals (directions as seen from the adder, i.e. the slave modport):
//   in_valid  in   operand beat offered
//   in_ready  out  beat accepted when in_valid && in_ready at a clock edge
//   x, y      in   operands A and B, WIDTH bits
//   c_in      in   carry-in (add) / active-low borrow-in (sub)
//   sub       in   0 = add, 1 = subtract, sampled with the beat
//   out_valid out  result beat present
//   out_ready in   consumer takes the result when out_valid && out_ready
//   sum       out  result, WIDTH bits
//   c_out     out  carry-out (add) / not-borrow (sub)
//   ovf       out  two's-complement signed overflow
//   zero      out  sum == 0
// The master modport is the producer/consumer side (operand entry + display).

interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid,
    output x,
    output y,
    output c_in,
    output sub,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  c_out,
    input  ovf,
    input  zero
  );

  modport slave (
    input  in_valid,
    input  x,
    input  y,
    input  c_in,
    input  sub,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output c_out,
    output ovf,
    output zero
  );

endinterface

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit adder/subtractor whose carry chain is cut into
// SEG-bit ripple segments, one register stage per segment (NSEG = WIDTH/SEG).
//
// Ports:
//   CLK    in  rising-edge clock
//   RST_N  in  asynchronous active-low reset; clears every valid bit and data reg
//   bus    slave side of pipelined_addsub_if (valid/ready operand and result beats)
//
// Stage k adds slice k of X and Y' (Y, or ~Y when subtracting) using the carry
// registered by stage k-1; stage 0 uses C_IN straight from the beat. Each
// stage register holds one full-width word per operand: slices below and at
// the stage's own position carry finished result bits, slices above still
// carry the untouched operand bits waiting for their turn. That one word
// therefore provides both the input skew and the output de-skew.
//
// Backpressure is uniform: when the last stage holds a beat the consumer
// does not take, nothing in the pipeline moves (no bubble squeezing).

module pipelined_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input logic               CLK,
  input logic               RST_N,
  pipelined_addsub_if.slave bus
);

  localparam int unsigned NSEG = WIDTH / SEG;

  // Pipeline state, one entry per segment stage.
  logic             valid_q [NSEG];
  logic             carry_q [NSEG];
  logic [WIDTH-1:0] a_q     [NSEG];  // result slices below, X slices above
  logic [WIDTH-1:0] b_q     [NSEG];  // Y' slices still to be consumed
  logic             ovf_q;
  logic             zero_q;

  logic             valid_d [NSEG];
  logic             carry_d [NSEG];
  logic [WIDTH-1:0] a_d     [NSEG];
  logic [WIDTH-1:0] b_d     [NSEG];
  logic             ovf_d;
  logic             zero_d;

  // Inputs seen by each stage's segment adder.
  logic             src_v   [NSEG];
  logic             src_c   [NSEG];
  logic [WIDTH-1:0] src_a   [NSEG];
  logic [WIDTH-1:0] src_b   [NSEG];
  logic [SEG:0]     seg_sum [NSEG];

  logic stall;
  logic accept;

  assign stall        = valid_q[NSEG-1] & ~bus.out_ready;
  assign accept       = bus.in_valid & ~stall;
  assign bus.in_ready = ~stall;

  always_comb begin
    // Stage 0 is fed by the incoming beat; the subtract decision is folded
    // into the B operand here so later stages never need the mode bit.
    src_v[0] = accept;
    src_c[0] = bus.c_in;
    src_a[0] = bus.x;
    src_b[0] = bus.sub ? ~bus.y : bus.y;
    for (int k = 1; k < NSEG; k++) begin
      src_v[k] = valid_q[k-1];
      src_c[k] = carry_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
    end

    for (int k = 0; k < NSEG; k++) begin
      seg_sum[k] = {1'b0, src_a[k][k*SEG +: SEG]}
                 + {1'b0, src_b[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, src_c[k]};
      valid_d[k]               = src_v[k];
      carry_d[k]               = seg_sum[k][SEG];
      a_d[k]                   = src_a[k];
      a_d[k][k*SEG +: SEG]     = seg_sum[k][SEG-1:0];
      b_d[k]                   = src_b[k];
    end

    // Carry into the MSB is a ^ b ^ sum at that bit, so overflow needs no
    // separate tap inside the final segment (works for SEG = 1 as well).
    ovf_d  = seg_sum[NSEG-1][SEG]
           ^ src_a[NSEG-1][WIDTH-1]
           ^ src_b[NSEG-1][WIDTH-1]
           ^ seg_sum[NSEG-1][SEG-1];
    zero_d = (a_d[NSEG-1] == '0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < NSEG; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < NSEG; k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.out_valid = valid_q[NSEG-1];
  assign bus.sum       = a_q[NSEG-1];
  assign bus.c_out     = carry_q[NSEG-1];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule
